// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad digit capture block: FSM state encoding,
// the row/column to hex key map and a one-hot test.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    RELEASE
  } state_t;

  // Indexed [row][col]; row 0 packed in the low 16 bits, col 0 in the low nibble.
  localparam logic [3:0][3:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational keypad decoder: one-hot row/col lines to a 4-bit hex key code.
// valid is low when either input is not exactly one-hot; code is then meaningless.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       valid,
  output logic [3:0] code
);

  logic [1:0] r_idx;
  logic [1:0] c_idx;

  always_comb begin
    r_idx = 2'd0;
    c_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row[i]) r_idx = 2'(i);
      if (col[i]) c_idx = 2'(i);
    end
    valid = is_onehot4(row) && is_onehot4(col);
    code  = KEY_MAP[r_idx][c_idx];
  end

endmodule

// File: rtl/keypad_digit_capture.sv
// Captures one hex digit per keypad press into a two-digit history with release debounce.
// Optional press counter output enabled by defining KEYPAD_PRESS_COUNT_EN.
module keypad_digit_capture
  import keypad_pkg::*;
#(
  parameter  int unsigned RELEASE_CYCLES = 60_000,
  localparam int unsigned CNT_W          = $clog2(RELEASE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  logic       en,
  output logic [3:0] digitNew,
  output logic [3:0] digitOld,
  output logic       keyValid,
  output logic       keyErr,
  output logic       keyHeld
`ifdef KEYPAD_PRESS_COUNT_EN
  ,
  output logic [7:0] pressCount
`endif
);

  // The HELD->RELEASE edge already consumed one low sample, so RELEASE needs
  // RELEASE_CYCLES-1 more; the counter tops out one below that.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(RELEASE_CYCLES - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dec_valid;
  logic [3:0]       dec_code;

  keypad_decode u_decode (
    .row   (row),
    .col   (col),
    .valid (dec_valid),
    .code  (dec_code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      digitNew <= 4'h0;
      digitOld <= 4'h0;
      keyValid <= 1'b0;
      keyErr   <= 1'b0;
      keyHeld  <= 1'b0;
    end else begin
      keyValid <= 1'b0;
      keyErr   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            state   <= HELD;
            keyHeld <= 1'b1;
            if (dec_valid) begin
              digitOld <= digitNew;
              digitNew <= dec_code;
              keyValid <= 1'b1;
            end else begin
              keyErr <= 1'b1;
            end
          end
        end
        HELD: begin
          if (!en) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          if (en) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state   <= IDLE;
            cnt     <= '0;
            keyHeld <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          keyHeld <= 1'b0;
        end
      endcase
    end
  end

`ifdef KEYPAD_PRESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pressCount <= 8'h00;
    end else if ((state == IDLE) && en && dec_valid && (pressCount != 8'hFF)) begin
      pressCount <= pressCount + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_keypad_digit_capture.sv
// Scoreboard bench for keypad_digit_capture with RELEASE_CYCLES=4.
module tb_keypad_digit_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic       en;
  logic [3:0] digitNew;
  logic [3:0] digitOld;
  logic       keyValid;
  logic       keyErr;
  logic       keyHeld;
`ifdef KEYPAD_PRESS_COUNT_EN
  logic [7:0] pressCount;
`endif

  int checks = 0;
  int passes = 0;
  int valid_seen = 0;
  int err_seen = 0;

  // Expected {digitNew, digitOld} for each keyValid pulse.
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_digit_capture #(
    .RELEASE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .en       (en),
    .digitNew (digitNew),
    .digitOld (digitOld),
    .keyValid (keyValid),
    .keyErr   (keyErr),
    .keyHeld  (keyHeld)
`ifdef KEYPAD_PRESS_COUNT_EN
    ,
    .pressCount (pressCount)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pop the scoreboard on every keyValid pulse.
  always @(negedge clk) begin
    if (keyValid === 1'b1 || keyErr === 1'b1) begin
      check("valid_err_exclusive", 32'(keyValid & keyErr), 32'd0);
    end
    if (keyErr === 1'b1) err_seen++;
    if (keyValid === 1'b1) begin
      valid_seen++;
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("sb_digitNew", 32'(digitNew), 32'(e[7:4]));
        check("sb_digitOld", 32'(digitOld), 32'(e[3:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    row   = 4'h0;
    col   = 4'h0;
    cyc(2);
    check("rst_digitNew", 32'(digitNew), 32'h0);
    check("rst_digitOld", 32'(digitOld), 32'h0);
    check("rst_keyValid", 32'(keyValid), 32'h0);
    check("rst_keyErr", 32'(keyErr), 32'h0);
    check("rst_keyHeld", 32'(keyHeld), 32'h0);
    reset = 1'b0;
    cyc(1);

    // Key 6, held 10 cycles: exactly one pulse, one cycle after the rise.
    row = 4'b0010; col = 4'b0100; en = 1'b1;
    exp_q.push_back({4'h6, 4'h0});
    cyc(1);
    check("t2_latency", 32'(keyValid), 32'd1);
    cyc(9);
    check("t2_keyHeld", 32'(keyHeld), 32'd1);
    check("t2_digitNew", 32'(digitNew), 32'h6);
    check("t2_digitOld", 32'(digitOld), 32'h0);
    check("t2_pulses", 32'(valid_seen), 32'd1);

    // Exactly 4 low samples re-arm; next press E shifts 6 down.
    en = 1'b0;
    cyc(4);
    check("t3_rearmed", 32'(keyHeld), 32'd0);
    row = 4'b1000; col = 4'b0001; en = 1'b1;
    exp_q.push_back({4'hE, 4'h6});
    cyc(1);
    check("t3_latency", 32'(keyValid), 32'd1);
    cyc(2);
    check("t3_digitNew", 32'(digitNew), 32'hE);
    check("t3_digitOld", 32'(digitOld), 32'h6);
    check("t3_pulses", 32'(valid_seen), 32'd2);

    // Release bounce with a different key on the lines: no capture.
    row = 4'b0001; col = 4'b0001;
    en = 1'b0;
    cyc(2);
    en = 1'b1;
    cyc(1);
    en = 1'b0;
    cyc(3);
    check("t4_still_held", 32'(keyHeld), 32'd1);
    cyc(1);
    check("t4_idle", 32'(keyHeld), 32'd0);
    check("t4_pulses", 32'(valid_seen), 32'd2);
    check("t4_digitNew", 32'(digitNew), 32'hE);
    check("t4_digitOld", 32'(digitOld), 32'h6);

    // Non-one-hot column: error pulse, digits untouched.
    row = 4'b0001; col = 4'b0110; en = 1'b1;
    cyc(1);
    check("t5_keyErr", 32'(keyErr), 32'd1);
    check("t5_keyValid", 32'(keyValid), 32'd0);
    cyc(1);
    check("t5_keyErr_pulse", 32'(keyErr), 32'd0);
    check("t5_digitNew", 32'(digitNew), 32'hE);
    check("t5_digitOld", 32'(digitOld), 32'h6);
    en = 1'b0;
    cyc(4);
    // Non-one-hot row, all-zero column as well.
    row = 4'b0011; col = 4'b0000; en = 1'b1;
    cyc(1);
    check("t5b_keyErr", 32'(keyErr), 32'd1);
    en = 1'b0;
    cyc(4);
    check("t5_err_count", 32'(err_seen), 32'd2);

    // Key C, then reset mid-press.
    row = 4'b0100; col = 4'b1000; en = 1'b1;
    exp_q.push_back({4'hC, 4'hE});
    cyc(4);
    check("t6_keyHeld", 32'(keyHeld), 32'd1);
`ifdef KEYPAD_PRESS_COUNT_EN
    check("t6_count_pre", 32'(pressCount), 32'd3);
`endif
    reset = 1'b1;
    cyc(1);
    check("t6_rst_keyHeld", 32'(keyHeld), 32'd0);
    check("t6_rst_digitNew", 32'(digitNew), 32'h0);
    check("t6_rst_digitOld", 32'(digitOld), 32'h0);
`ifdef KEYPAD_PRESS_COUNT_EN
    check("t6_rst_count", 32'(pressCount), 32'd0);
`endif
    reset = 1'b0;
    en = 1'b0;
    cyc(1);
    // After reset the FSM must be armed straight away.
    row = 4'b0001; col = 4'b0010; en = 1'b1;
    exp_q.push_back({4'h2, 4'h0});
    cyc(1);
    check("t6_post_rst_capture", 32'(keyValid), 32'd1);
    en = 1'b0;
    cyc(4);

`ifdef KEYPAD_PRESS_COUNT_EN
    begin
      logic [3:0] prev;
      prev = 4'h2;
      for (int i = 0; i < 300; i++) begin
        row = 4'b0001; col = 4'b0001; en = 1'b1;
        exp_q.push_back({4'h1, prev});
        prev = 4'h1;
        cyc(2);
        en = 1'b0;
        cyc(4);
      end
    end
    check("t6_count_sat", 32'(pressCount), 32'hFF);
`endif

    cyc(3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
